proc_control_unit: RTL

- Moore FSM that sequences the ProjectB datapath: PC, instruction register, data RAM, register file, ALU and the 16-bit write-back mux.
- Decodes the 16-bit instruction held in the IR.
- Drives every datapath control: PC clear/increment, IR load, RAM address and write, register-file addresses and write enable, ALU function, and the write-back mux select RF_s (1 = RAM read data, 0 = ALU result).

---
 rtl/proc_control_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/proc_control_unit.sv
// -----------------------------------------------------------------------------
// proc_control_unit
//   Moore control FSM for the ProjectB datapath. It sequences the PC, the
//   instruction register, data RAM, register file, ALU and the write-back mux,
//   and decodes the 16-bit instruction held in the IR.
//
//   Ports
//     Clk         in   system clock, rising edge
//     ResetN      in   asynchronous active-low reset
//     IR          in   [15:0] current instruction
//     PC_clr      out  clear program counter
//     PC_up       out  increment program counter
//     IR_ld       out  load IR from instruction memory
//     D_addr      out  [7:0] data RAM address
//     D_wr        out  data RAM write enable
//     RF_s        out  write-back select (1 = RAM data, 0 = ALU result)
//     RF_W_addr   out  [3:0] register-file write address
//     RF_W_en     out  register-file write enable
//     RF_Ra_addr  out  [3:0] register-file read port A address
//     RF_Rb_addr  out  [3:0] register-file read port B address
//     ALU_s0      out  [2:0] ALU function select
//     StateOut    out  [3:0] current state encoding (debug)
// -----------------------------------------------------------------------------
module proc_control_unit #(
    parameter logic [2:0] ALU_ADD = 3'd1,
    parameter logic [2:0] ALU_SUB = 3'd2
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  StateOut
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    state_t state_q, state_d;

    logic [3:0] opcode;
    assign opcode = IR[15:12];

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    // OP_NOOP and every unassigned opcode behave as NOOP
                    default:  state_d = S_NOOP;
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Moore outputs: everything defaults to 0 (addresses included), so
    // RF_s falls back to the ALU path outside the load states.
    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = 8'd0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s0     = 3'd0;
        case (state_q)
            S_INIT:  PC_clr = 1'b1;
            S_FETCH: begin
                PC_up = 1'b1;
                IR_ld = 1'b1;
            end
            S_STORE: begin
                D_addr     = IR[11:4];
                RF_Ra_addr = IR[3:0];
                D_wr       = 1'b1;
            end
            // LOAD_A only waits out the synchronous RAM read; LOAD_B commits.
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_addr = IR[3:0];
                RF_W_en   = (state_q == S_LOAD_B);
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign StateOut = state_q;

    // Suppress an unused-constant warning for the explicit NOOP opcode name.
    logic unused_noop;
    assign unused_noop = ^OP_NOOP;

endmodule
